// File: rtl/ahb_lite_nslave_mux.sv
// AHB-Lite single-master interconnect: address decode, data-phase owner tracking,
// response mux, built-in erroring default slave and a saturating bus-error counter.
module ahb_lite_nslave_mux #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {4{32'hF000_0000}},
    parameter int ERRCNT_W   = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [3:0]                   HPROT,
    input  logic [DATA_W-1:0]            HWDATA,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [ADDR_W-1:0]            haddr_s,
    output logic [1:0]                   htrans_s,
    output logic                         hwrite_s,
    output logic [2:0]                   hsize_s,
    output logic [2:0]                   hburst_s,
    output logic [3:0]                   hprot_s,
    output logic [DATA_W-1:0]            hwdata_s,
    output logic [NUM_SLAVES-1:0]        hsel_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    output logic [ERRCNT_W-1:0]          err_cnt,
    input  logic                         err_clr
);

    typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_t;

    logic [NUM_SLAVES-1:0] match;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_hit;
    logic [NUM_SLAVES:0]   dsel_reg;
    logic [NUM_SLAVES:0]   dsel_next;
    ds_state_t             ds_state_reg;
    logic                  ds_ready_reg;
    logic                  ds_resp_reg;
    logic                  slv_ready;
    logic                  slv_resp;
    logic [DATA_W-1:0]     slv_rdata;
    logic                  ds_start;
    logic                  err_hit;
    logic [ERRCNT_W-1:0]   err_cnt_reg;

    assign haddr_s  = HADDR;
    assign htrans_s = HTRANS;
    assign hwrite_s = HWRITE;
    assign hsize_s  = HSIZE;
    assign hburst_s = HBURST;
    assign hprot_s  = HPROT;
    assign hwdata_s = HWDATA;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign match[gi] = ((HADDR & SLV_MASK[gi*ADDR_W +: ADDR_W]) ==
                                (SLV_BASE[gi*ADDR_W +: ADDR_W] & SLV_MASK[gi*ADDR_W +: ADDR_W]));
        end
    endgenerate

    // Lowest matching index wins so overlapping windows still give a one-hot select.
    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (match[i] && !dec_hit) begin
                dec_sel[i] = 1'b1;
                dec_hit    = 1'b1;
            end
        end
    end

    assign hsel_s    = dec_sel;
    assign dsel_next = {~dec_hit, dec_sel};

    always_comb begin
        slv_ready = 1'b0;
        slv_resp  = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_reg[i]) begin
                slv_ready = hreadyout_s[i];
                slv_resp  = hresp_s[i];
                slv_rdata = hrdata_s[i*DATA_W +: DATA_W];
            end
        end
    end

    assign HREADY = dsel_reg[NUM_SLAVES] ? ds_ready_reg : slv_ready;
    assign HRESP  = dsel_reg[NUM_SLAVES] ? ds_resp_reg  : slv_resp;
    assign HRDATA = dsel_reg[NUM_SLAVES] ? '0           : slv_rdata;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_reg <= {1'b1, {NUM_SLAVES{1'b0}}};
        end else if (HREADY) begin
            dsel_reg <= dsel_next;
        end
    end

    // Only active transfers to unmapped space error; IDLE/BUSY get a zero-wait OKAY.
    assign ds_start = HREADY && !dec_hit && HTRANS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state_reg <= DS_OK;
            ds_ready_reg <= 1'b1;
            ds_resp_reg  <= 1'b0;
        end else begin
            case (ds_state_reg)
                DS_ERR1: begin
                    ds_state_reg <= DS_ERR2;
                    ds_ready_reg <= 1'b1;
                    ds_resp_reg  <= 1'b1;
                end
                default: begin
                    if (ds_start) begin
                        ds_state_reg <= DS_ERR1;
                        ds_ready_reg <= 1'b0;
                        ds_resp_reg  <= 1'b1;
                    end else begin
                        ds_state_reg <= DS_OK;
                        ds_ready_reg <= 1'b1;
                        ds_resp_reg  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign err_hit = !HREADY && HRESP;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_cnt_reg <= '0;
        end else if (err_clr) begin
            err_cnt_reg <= '0;
        end else if (err_hit && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign err_cnt = err_cnt_reg;

endmodule
